// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for an 11-bit Fibonacci LFSR: loads seeds, streams one word per valid/ready handshake.
// First word the cycle after start; the state advances only on a handshake. Period meter under `LFSR_PERIOD_EN.
module lfsr_burst_ctrl #(
  parameter int               WIDTH    = 11,
  parameter logic [WIDTH-1:0] TAPS     = 11'h500,
  parameter logic [WIDTH-1:0] RST_SEED = 11'h001,
  parameter int               CNT_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  fsm_t             fsm, fsm_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_step, load_val;
  logic [CNT_W-1:0] remaining;
  logic             hs, load_en, start_en, last;

  assign lfsr_step = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  // A zero seed would lock the register at zero, so it is replaced by 1.
  assign load_val  = (seed == '0) ? ONE_W : seed;
  assign out_data  = lfsr;

  always_comb begin
    fsm_nxt   = fsm;
    out_valid = 1'b0;
    busy      = 1'b0;
    hs        = 1'b0;
    load_en   = 1'b0;
    start_en  = 1'b0;
    last      = 1'b0;
    case (fsm)
      IDLE: begin
        load_en  = seed_load;
        start_en = start;
        if (start && burst_len != '0) fsm_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        hs        = out_ready;
        last      = out_ready && (remaining == ONE_C);
        if (last) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= RST_SEED;
      remaining <= '0;
      done      <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      done <= last;
      if (load_en) begin
        lfsr   <= load_val;
        lockup <= (seed == '0);
      end else if (hs) begin
        lfsr <= lfsr_step;
      end
      if (start_en) begin
        if (burst_len != '0) remaining <= burst_len;
        else                 done      <= 1'b1;
      end else if (hs) begin
        remaining <= remaining - ONE_C;
      end
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [CNT_W-1:0] steps, period_r;
  logic [WIDTH-1:0] seed_ref;
  logic             pv;

  // Only the first return to the seed is recorded; later wraps leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      steps    <= '0;
      period_r <= '0;
      pv       <= 1'b0;
      seed_ref <= RST_SEED;
    end else if (load_en) begin
      steps    <= '0;
      period_r <= '0;
      pv       <= 1'b0;
      seed_ref <= load_val;
    end else if (hs) begin
      if (steps != '1) steps <= steps + ONE_C;
      if (!pv && lfsr_step == seed_ref) begin
        period_r <= steps + ONE_C;
        pv       <= 1'b1;
      end
    end
  end

  assign period       = period_r;
  assign period_valid = pv;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl: directed bursts plus randomized bursts against a word-level reference model.
module tb_lfsr_burst_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] seed;
  logic        seed_load;
  logic        start;
  logic [11:0] burst_len;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_data;
  logic        busy;
  logic        done;
  logic        lockup;
  logic [11:0] period;
  logic        period_valid;

  int vectors = 0;
  int miscompares = 0;

  // model of the generator as seen from outside: current word and lockup flag
  int m_lfsr;
  bit m_lockup;

  lfsr_burst_ctrl dut (
    .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load), .start(start),
    .burst_len(burst_len), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .lockup(lockup), .period(period), .period_valid(period_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // x^11 + x^9 + 1: shift left in 11 bits, new low bit is bit10 xor bit8
  function automatic int lfsr_next(input int s);
    return ((s * 2) % 2048) + (((s >> 10) ^ (s >> 8)) & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'(m_lfsr));
    chk({tag, "_lockup"}, 32'(lockup), 32'(m_lockup));
  endtask

  task automatic load_only(input logic [10:0] sd);
    seed_load = 1'b1; seed = sd; start = 1'b0;
    m_lfsr   = (sd == 0) ? 1 : int'(sd);
    m_lockup = (sd == 0);
    tick();
    seed_load = 1'b0;
    chk_idle("load");
    chk("load_done", 32'(done), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle_hold");
    end
    out_ready = 1'b0;
  endtask

  task automatic burst(input bit do_load, input logic [10:0] sd, input int len,
                       input int ready_pct, input int stall_at);
    int got, cyc, stalls;
    seed_load = do_load; seed = sd; start = 1'b1; burst_len = 12'(len); out_ready = 1'b1;
    if (do_load) begin
      m_lfsr   = (sd == 0) ? 1 : int'(sd);
      m_lockup = (sd == 0);
    end
    tick();
    seed_load = 1'b0; start = 1'b0;
    if (len == 0) begin
      chk("zero_len_done", 32'(done), 32'd1);
      chk_idle("zero_len");
      tick();
      chk("zero_len_done_pulse", 32'(done), 32'd0);
      chk_idle("zero_len_after");
      return;
    end
    got = 0; cyc = 0; stalls = 0;
    while (got < len && cyc < 20000) begin
      chk("run_valid", 32'(out_valid), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_data", 32'(out_data), 32'(m_lfsr));
      chk("run_done", 32'(done), 32'd0);
      chk("run_lockup", 32'(lockup), 32'(m_lockup));
      if (got == stall_at && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = (int'($urandom_range(99)) < ready_pct);
      end
      // loads and starts while running must be ignored
      seed_load = ($urandom_range(7) == 0);
      seed      = 11'($urandom);
      start     = ($urandom_range(7) == 0);
      burst_len = 12'($urandom);
      tick();
      if (out_ready) begin
        m_lfsr = lfsr_next(m_lfsr);
        got++;
      end
      cyc++;
    end
    seed_load = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk("word_count", 32'(got), 32'(len));
    chk("end_done", 32'(done), 32'd1);
    chk_idle("end");
`ifndef LFSR_PERIOD_EN
    chk("period_off", 32'(period), 32'd0);
    chk("period_valid_off", 32'(period_valid), 32'd0);
`endif
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
    chk_idle("after_end");
  endtask

  initial begin
    reset = 1'b1; seed = '0; seed_load = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b0;
    m_lfsr = 1; m_lockup = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_period_valid", 32'(period_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk_idle("post_reset");

    // seed 001, three words at full rate
    burst(1'b1, 11'h001, 3, 100, -1);
    // seed 400: second word is 001 via feedback
    burst(1'b1, 11'h400, 2, 100, -1);
    // stall five cycles on the second word
    burst(1'b1, 11'h2a5, 4, 100, 1);
    // zero seed is replaced by 1 and flagged; zero-length start
    burst(1'b1, 11'h000, 3, 100, -1);
    burst(1'b0, 11'h000, 0, 100, -1);
    load_only(11'h000);
    load_only(11'h155);
    burst(1'b0, 11'h000, 5, 60, -1);

    // reset in the middle of a burst
    seed_load = 1'b1; seed = 11'h123; start = 1'b1; burst_len = 12'd10; out_ready = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    chk("pre_abort_data", 32'(out_data), 32'h123);
    tick();
    tick();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    m_lfsr = 1; m_lockup = 1'b0;
    chk_idle("abort");
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk_idle("abort_after");

    for (int i = 0; i < 14; i++) begin
      logic [10:0] sd;
      sd = ($urandom_range(5) == 0) ? 11'h000 : 11'($urandom);
      burst(bit'($urandom_range(1)), sd, int'($urandom_range(40)),
            30 + int'($urandom_range(70)), int'($urandom_range(6)) - 1);
    end

`ifdef LFSR_PERIOD_EN
    burst(1'b1, 11'h001, 2047, 100, -1);
    chk("period_value", 32'(period), 32'd2047);
    chk("period_valid_set", 32'(period_valid), 32'd1);
    load_only(11'h001);
    chk("period_cleared", 32'(period), 32'd0);
    chk("period_valid_cleared", 32'(period_valid), 32'd0);
`else
    burst(1'b1, 11'h001, 2047, 100, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
